data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//   Word-addressed data memory for the single-cycle/pipelined MIPS datapath (MEM stage).
//   Stores 32-bit words addressed by a byte address from the ALU.
//   Writes are synchronous on the rising clock edge; reads are combinational.
//   Sits between the ALU result / rt forwarding path and the write-back mux.
// PARAMETERS
//   DATA_WIDTH   32     width of each memory word and of WriteData/ReadData
//   DEPTH        1024   number of words stored (4 KiB)
//   INDEX_BITS   10     log2(DEPTH); word index = Address[INDEX_BITS+1:2]
// PORTS
//   Clk        in   1    system clock; all state changes on rising edge
//   Rst        in   1    synchronous, active-high reset
//   Address    in   32   byte address; bits [1:0] ignored (word aligned)
//   WriteData  in   32   data stored when MemWrite=1
//   MemWrite   in   1    write enable, sampled at rising edge of Clk
//   MemRead    in   1    read enable (combinational gate on ReadData)
//   ReadData   out  32   word at Address when MemRead=1, else 32'h0
// BEHAVIOUR
//   - Reset: one clock is single, synchronous reset is active-high (Clk, Rst).
//     On a rising edge with Rst=1 every memory word is cleared to 0. Rst has
//     priority over MemWrite (write in the same cycle is discarded).
//   - ReadData is a purely combinational function of Rst-cleared contents,
//     Address and MemRead; no output register. ReadData = 0 while MemRead=0,
//     including during and after reset until MemRead asserts.
//   - Index: idx = Address[INDEX_BITS+1:2]. Address bits above INDEX_BITS+1
//     are ignored, so addresses beyond DEPTH*4 alias (wrap) into the array.
//     Address[1:0] ignored: Address 5,6,7 access the same word as 4.
//   - Write: rising edge of Clk with Rst=0 and MemWrite=1 -> mem[idx] <= WriteData.
//     Full 32-bit word write only; no byte/halfword enables.
//   - Write latency: new value visible on ReadData immediately after the
//     writing edge (same Address, MemRead=1).
//   - MemRead and MemWrite both 1: ReadData shows pre-edge contents until the
//     edge, then the newly written value (read-before-write within a cycle).
//   - MemWrite=0: memory contents unchanged regardless of Address/WriteData.
//   - No X propagation: all words start at 0 from the first reset; contents
//     before the first reset are undefined and must not be relied on.
//   - Inputs change away from the rising edge (bench drives on falling edge);
//     no internal synchronisation is required.
// TESTING
//   1. Rst=1 for one edge, then MemRead=1 at Address 0,4,4092 -> ReadData=0 each.
//   2. MemWrite=1 writing 4->addr4, 8->addr8, 12->addr12 on three successive edges;
//      then MemWrite=0, MemRead=1 at 4,8,12 -> ReadData=4,8,12.
//   3. Rewrite addr4=44, addr8=88, addr12=132; read back -> 44,88,132; also
//      MemRead=0 at addr8 -> ReadData=0.
//   4. Alias/alignment: write 32'hDEADBEEF to Address 16; read Address 19 and
//      Address 16+4096 -> 32'hDEADBEEF both.
//   5. Simultaneous: MemRead=1, MemWrite=1, Address 8 (holds 88), WriteData=77 ->
//      ReadData=88 before edge, 77 after edge.
//   6. Rst=1 together with MemWrite=1 (addr12, data 5) -> after edge, read addr12
//      and addr4 -> 0 (reset wins, all words cleared).

Source files
------------

// File: rtl/data_memory.sv
// Word-addressed data memory for the MIPS MEM stage.
// Writes are synchronous, reads are combinational, and a synchronous reset clears every word.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int INDEX_BITS = 10
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [INDEX_BITS-1:0] idx;

  // High address bits alias into the array, and the byte offset selects nothing.
  assign idx = Address[INDEX_BITS+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{Address[31:INDEX_BITS+2], Address[1:0]};

  // NOTE: clearing every word on reset turns the array into plain flops, not a RAM macro;
  // the datapath relies on reading zeros from any address after reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (MemWrite) begin
      mem[idx] <= WriteData;
    end
  end

  assign ReadData = MemRead ? mem[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed vector bench for data_memory: table of one-cycle vectors plus
// hand-written sequences for read-during-write and reset-versus-write.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;

  int errors = 0;
  int checks = 0;

  data_memory dut (
    .Clk      (clk),
    .Rst      (rst),
    .Address  (address),
    .WriteData(write_data),
    .MemWrite (mem_write),
    .MemRead  (mem_read),
    .ReadData (read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;  // ReadData expected just before the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic wr, input logic rd,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp);
    vec_t v;
    v.name = name; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    rst = r; mem_write = wr; mem_read = rd; address = addr; write_data = wdata;
    #1;
  endtask

  initial begin
    // Reset and basic reads
    add("rst_rd0",      0, 1, 32'd0,    32'h0,        32'd0);
    add("rst_rd4",      0, 1, 32'd4,    32'h0,        32'd0);
    add("rst_rd4092",   0, 1, 32'd4092, 32'h0,        32'd0);
    // First writes, then read back
    add("wr4",          1, 0, 32'd4,    32'd4,        32'd0);
    add("wr8",          1, 0, 32'd8,    32'd8,        32'd0);
    add("wr12",         1, 0, 32'd12,   32'd12,       32'd0);
    add("rd4",          0, 1, 32'd4,    32'h0,        32'd4);
    add("rd8",          0, 1, 32'd8,    32'h0,        32'd8);
    add("rd12",         0, 1, 32'd12,   32'h0,        32'd12);
    // Overwrite and read back; read disabled gives zero
    add("rewr4",        1, 0, 32'd4,    32'd44,       32'd0);
    add("rewr8",        1, 0, 32'd8,    32'd88,       32'd0);
    add("rewr12",       1, 0, 32'd12,   32'd132,      32'd0);
    add("rerd4",        0, 1, 32'd4,    32'h0,        32'd44);
    add("rerd8",        0, 1, 32'd8,    32'h0,        32'd88);
    add("rerd12",       0, 1, 32'd12,   32'h0,        32'd132);
    add("rd_off8",      0, 0, 32'd8,    32'h0,        32'd0);
    // Alignment and aliasing
    add("wr16",         1, 0, 32'd16,   32'hDEADBEEF, 32'd0);
    add("rd19",         0, 1, 32'd19,   32'h0,        32'hDEADBEEF);
    add("rd4112",       0, 1, 32'd4112, 32'h0,        32'hDEADBEEF);
    add("rd4100",       0, 1, 32'd4100, 32'h0,        32'd44);
    // No write enable: garbage on WriteData must not land
    add("nowr8",        0, 1, 32'd8,    32'hFFFFFFFF, 32'd88);
    add("nowr8_after",  0, 1, 32'd8,    32'h12345678, 32'd88);

    rst = 1'b1; mem_write = 1'b0; mem_read = 1'b0; address = '0; write_data = '0;
    #1;
    @(posedge clk);
    #1;
    check("reset_rd_off", read_data, 32'd0);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      check(vecs[i].name, read_data, vecs[i].exp);
    end

    // Read and write in the same cycle: old data before the edge, new data after
    drive(1'b0, 1'b1, 1'b1, 32'd8, 32'd77);
    check("rw_pre_edge", read_data, 32'd88);
    @(posedge clk);
    #1;
    check("rw_post_edge", read_data, 32'd77);
    drive(1'b0, 1'b0, 1'b1, 32'd8, 32'h0);
    check("rw_hold", read_data, 32'd77);

    // Reset together with a write: reset wins and clears everything
    drive(1'b1, 1'b1, 1'b1, 32'd12, 32'd5);
    check("rst_wr_pre_edge", read_data, 32'd132);
    drive(1'b0, 1'b0, 1'b1, 32'd12, 32'h0);
    check("rst_wr_rd12", read_data, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'd4, 32'h0);
    check("rst_wr_rd4", read_data, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'd16, 32'h0);
    check("rst_wr_rd16", read_data, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'd8, 32'h0);
    check("rst_wr_rd8", read_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
